mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 128 ++++++++++++
 tb/tb_mem_stage.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory pipeline stage: forms the writeback value and buffers results in a 2-entry FIFO.
// Optional MEM_ALIGNED_LOAD_EN selects byte/half lanes by address and flags misaligned loads.
module mem_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   exe_to_mem_valid,
  output logic                                   mem_to_exe_ready,
  input  logic [DATA_WIDTH*2+REG_ADDR_WIDTH+3:0] exe_to_mem_bus,
  output logic                                   mem_to_wb_valid,
  input  logic                                   wb_to_mem_ready,
  output logic [DATA_WIDTH+REG_ADDR_WIDTH:0]     mem_to_wb_bus,
  output logic                                   mem_fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0]              mem_fwd_addr,
  output logic [DATA_WIDTH-1:0]                  mem_fwd_data
`ifdef MEM_ALIGNED_LOAD_EN
  ,
  output logic                                   misalign_err
`endif
);

  localparam int OUT_W = DATA_WIDTH + REG_ADDR_WIDTH + 1;

  logic                      bus_regw;
  logic [REG_ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0]     bus_alu;
  logic [2:0]                bus_load_inst;
  logic [DATA_WIDTH-1:0]     bus_load_data;

  assign {bus_regw, bus_addr, bus_alu, bus_load_inst, bus_load_data} = exe_to_mem_bus;

  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] wdata;
`ifdef MEM_ALIGNED_LOAD_EN
  logic                  misaligned;
`endif

  always_comb begin
    byte_sel = bus_load_data[7:0];
    half_sel = bus_load_data[15:0];
`ifdef MEM_ALIGNED_LOAD_EN
    misaligned = 1'b0;
    case (bus_alu[1:0])
      2'd0:    byte_sel = bus_load_data[7:0];
      2'd1:    byte_sel = bus_load_data[15:8];
      2'd2:    byte_sel = bus_load_data[23:16];
      default: byte_sel = bus_load_data[31:24];
    endcase
    half_sel = bus_alu[1] ? bus_load_data[31:16] : bus_load_data[15:0];
    case (bus_load_inst)
      3'd2, 3'd5:       misaligned = bus_alu[0];
      3'd3, 3'd6, 3'd7: misaligned = |bus_alu[1:0];
      default:          misaligned = 1'b0;
    endcase
`endif
    case (bus_load_inst)
      3'd0:    wdata = bus_alu;
      3'd1:    wdata = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      3'd2:    wdata = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      3'd4:    wdata = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      3'd5:    wdata = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: wdata = bus_load_data;  // lw and the reserved encodings
    endcase
`ifdef MEM_ALIGNED_LOAD_EN
    if (misaligned) begin
      wdata = '0;
    end
`endif
  end

  logic [OUT_W-1:0] entry_reg [2];
  logic [1:0]       count_reg, count_next;
  logic             wr_ptr_reg, rd_ptr_reg;
  logic             enq, deq;
  logic [OUT_W-1:0] head;

  assign mem_to_exe_ready = (count_reg != 2'd2);
  assign mem_to_wb_valid  = (count_reg != 2'd0);
  assign enq = exe_to_mem_valid && mem_to_exe_ready;
  assign deq = mem_to_wb_valid && wb_to_mem_ready;

  always_comb begin
    count_next = count_reg;
    case ({enq, deq})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // x0 writes are dropped here so writeback and forwarding never see them.
  always_ff @(posedge clk) begin
    if (enq) begin
      entry_reg[wr_ptr_reg] <= {bus_regw && (bus_addr != '0), bus_addr, wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (enq) wr_ptr_reg <= ~wr_ptr_reg;
      if (deq) rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

`ifdef MEM_ALIGNED_LOAD_EN
  logic misalign_err_reg;
  always_ff @(posedge clk) begin
    if (rst) misalign_err_reg <= 1'b0;
    else     misalign_err_reg <= enq && misaligned;
  end
  assign misalign_err = misalign_err_reg;
`endif

  assign head          = entry_reg[rd_ptr_reg];
  assign mem_to_wb_bus = head;
  assign mem_fwd_valid = mem_to_wb_valid && head[OUT_W-1];
  assign mem_fwd_addr  = head[DATA_WIDTH +: REG_ADDR_WIDTH];
  assign mem_fwd_data  = head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; aligned-load checks build only with MEM_ALIGNED_LOAD_EN.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        exe_to_mem_valid;
  logic        mem_to_exe_ready;
  logic [72:0] exe_to_mem_bus;
  logic        mem_to_wb_valid;
  logic        wb_to_mem_ready;
  logic [37:0] mem_to_wb_bus;
  logic        mem_fwd_valid;
  logic [4:0]  mem_fwd_addr;
  logic [31:0] mem_fwd_data;
`ifdef MEM_ALIGNED_LOAD_EN
  logic        misalign_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk              (clk),
    .rst              (rst),
    .exe_to_mem_valid (exe_to_mem_valid),
    .mem_to_exe_ready (mem_to_exe_ready),
    .exe_to_mem_bus   (exe_to_mem_bus),
    .mem_to_wb_valid  (mem_to_wb_valid),
    .wb_to_mem_ready  (wb_to_mem_ready),
    .mem_to_wb_bus    (mem_to_wb_bus),
    .mem_fwd_valid    (mem_fwd_valid),
    .mem_fwd_addr     (mem_fwd_addr),
    .mem_fwd_data     (mem_fwd_data)
`ifdef MEM_ALIGNED_LOAD_EN
    ,
    .misalign_err     (misalign_err)
`endif
  );

  function automatic logic [72:0] mk_bus(input logic regw, input logic [4:0] addr,
                                         input logic [31:0] alu, input logic [2:0] li,
                                         input logic [31:0] ld);
    return {regw, addr, alu, li, ld};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    exe_to_mem_valid = 1'b0;
    wb_to_mem_ready = 1'b1;
    exe_to_mem_bus = '0;
    step();
    step();
    checks++;
    if (mem_to_wb_valid !== 1'b0 || mem_fwd_valid !== 1'b0 || mem_to_exe_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid=%b fwd=%b ready=%b expected 0 0 1",
               mem_to_wb_valid, mem_fwd_valid, mem_to_exe_ready);
    end
    rst = 1'b0;
    step();
    $display("reset: valid=%b ready=%b", mem_to_wb_valid, mem_to_exe_ready);
  endtask

  task automatic test_lb();
    exe_to_mem_bus = mk_bus(1'b1, 5'd5, 32'h0, 3'd1, 32'h0000_00F0);
    exe_to_mem_valid = 1'b1;
    step();
    exe_to_mem_valid = 1'b0;
    checks++;
    if (mem_to_wb_valid !== 1'b1 || mem_to_wb_bus !== {1'b1, 5'd5, 32'hFFFF_FFF0}) begin
      errors++;
      $display("FAIL lb_bus: valid=%b bus=%h expected 1 %h", mem_to_wb_valid, mem_to_wb_bus,
               {1'b1, 5'd5, 32'hFFFF_FFF0});
    end
    checks++;
    if (mem_fwd_valid !== 1'b1 || mem_fwd_addr !== 5'd5 || mem_fwd_data !== 32'hFFFF_FFF0) begin
      errors++;
      $display("FAIL lb_fwd: fwd=%b addr=%0d data=%h expected 1 5 fffffff0",
               mem_fwd_valid, mem_fwd_addr, mem_fwd_data);
    end
    $display("lb: bus=%h fwd=%b", mem_to_wb_bus, mem_fwd_valid);
    step();
    checks++;
    if (mem_to_wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL lb_drain: valid=%b expected 0", mem_to_wb_valid);
    end
  endtask

  // Back-to-back loads of every encoding with writeback always ready.
  task automatic test_load_ext();
    logic [2:0]  li_t  [8] = '{3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    logic [31:0] ld_t  [8] = '{32'h1234_ABCD, 32'h5555_5555, 32'hAAAA_AA7F, 32'h0000_8001,
                               32'hCAFE_F00D, 32'h1111_11FF, 32'h8765_4321, 32'h0BAD_BEEF};
    logic [31:0] exp_t [8] = '{32'h0000_ABCD, 32'hDEAD_BEEF, 32'h0000_007F, 32'hFFFF_8001,
                               32'hCAFE_F00D, 32'h0000_00FF, 32'h8765_4321, 32'h0BAD_BEEF};
    for (int i = 0; i < 8; i++) begin
      exe_to_mem_bus = mk_bus(1'b1, 5'(i + 1), (li_t[i] == 3'd0) ? 32'hDEAD_BEEF : 32'h0,
                              li_t[i], ld_t[i]);
      exe_to_mem_valid = 1'b1;
      step();
      checks++;
      if (mem_to_wb_bus !== {1'b1, 5'(i + 1), exp_t[i]} || mem_to_wb_valid !== 1'b1) begin
        errors++;
        $display("FAIL load_ext[%0d]: li=%0d bus=%h expected %h", i, li_t[i], mem_to_wb_bus,
                 {1'b1, 5'(i + 1), exp_t[i]});
      end
      $display("load li=%0d ld=%h -> wdata=%h", li_t[i], ld_t[i], mem_fwd_data);
    end
    exe_to_mem_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    wb_to_mem_ready = 1'b0;
    exe_to_mem_bus = mk_bus(1'b1, 5'd1, 32'h11, 3'd0, 32'h0);
    exe_to_mem_valid = 1'b1;
    step();
    checks++;
    if (mem_to_exe_ready !== 1'b1 || mem_to_wb_bus[31:0] !== 32'h11) begin
      errors++;
      $display("FAIL bp_one: ready=%b data=%h expected 1 11", mem_to_exe_ready, mem_to_wb_bus[31:0]);
    end
    exe_to_mem_bus = mk_bus(1'b1, 5'd2, 32'h22, 3'd0, 32'h0);
    step();
    checks++;
    if (mem_to_exe_ready !== 1'b0 || mem_to_wb_bus[31:0] !== 32'h11) begin
      errors++;
      $display("FAIL bp_full: ready=%b data=%h expected 0 11", mem_to_exe_ready, mem_to_wb_bus[31:0]);
    end
    exe_to_mem_bus = mk_bus(1'b1, 5'd3, 32'h33, 3'd0, 32'h0);
    step();
    checks++;
    if (mem_to_exe_ready !== 1'b0 || mem_to_wb_bus[31:0] !== 32'h11) begin
      errors++;
      $display("FAIL bp_hold: ready=%b data=%h expected 0 11", mem_to_exe_ready, mem_to_wb_bus[31:0]);
    end
    wb_to_mem_ready = 1'b1;
    step();
    checks++;
    if (mem_to_exe_ready !== 1'b1 || mem_to_wb_bus[31:0] !== 32'h22) begin
      errors++;
      $display("FAIL bp_release_a: ready=%b data=%h expected 1 22", mem_to_exe_ready, mem_to_wb_bus[31:0]);
    end
    step();
    checks++;
    if (mem_to_wb_valid !== 1'b1 || mem_to_wb_bus[31:0] !== 32'h33) begin
      errors++;
      $display("FAIL bp_release_b: valid=%b data=%h expected 1 33", mem_to_wb_valid, mem_to_wb_bus[31:0]);
    end
    exe_to_mem_valid = 1'b0;
    step();
    checks++;
    if (mem_to_wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: valid=%b expected 0", mem_to_wb_valid);
    end
    $display("backpressure: A,B,C delivered, valid=%b", mem_to_wb_valid);
  endtask

  task automatic test_back_to_back();
    wb_to_mem_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      exe_to_mem_bus = mk_bus(1'b1, 5'd9, 32'(i), 3'd0, 32'h0);
      exe_to_mem_valid = 1'b1;
      step();
      checks++;
      if (mem_to_wb_valid !== 1'b1 || mem_to_exe_ready !== 1'b1 || mem_to_wb_bus[31:0] !== 32'(i)) begin
        errors++;
        $display("FAIL b2b[%0d]: valid=%b ready=%b data=%h expected 1 1 %h", i,
                 mem_to_wb_valid, mem_to_exe_ready, mem_to_wb_bus[31:0], 32'(i));
      end
      $display("b2b op %0d: data=%h", i, mem_to_wb_bus[31:0]);
    end
    exe_to_mem_valid = 1'b0;
    step();
    checks++;
    if (mem_to_wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: valid=%b expected 0", mem_to_wb_valid);
    end
  endtask

  task automatic test_x0_store();
    exe_to_mem_bus = mk_bus(1'b1, 5'd0, 32'h7, 3'd0, 32'h0);
    exe_to_mem_valid = 1'b1;
    step();
    checks++;
    if (mem_to_wb_bus !== {1'b0, 5'd0, 32'h7} || mem_fwd_valid !== 1'b0) begin
      errors++;
      $display("FAIL x0: bus=%h fwd=%b expected %h 0", mem_to_wb_bus, mem_fwd_valid, {1'b0, 5'd0, 32'h7});
    end
    exe_to_mem_bus = mk_bus(1'b0, 5'd3, 32'h100, 3'd0, 32'h0);
    step();
    checks++;
    if (mem_to_wb_bus !== {1'b0, 5'd3, 32'h100} || mem_fwd_valid !== 1'b0 || mem_to_wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL store: bus=%h fwd=%b expected %h 0", mem_to_wb_bus, mem_fwd_valid, {1'b0, 5'd3, 32'h100});
    end
    $display("x0/store: bus=%h fwd=%b", mem_to_wb_bus, mem_fwd_valid);
    exe_to_mem_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    wb_to_mem_ready = 1'b0;
    exe_to_mem_bus = mk_bus(1'b1, 5'd4, 32'h44, 3'd0, 32'h0);
    exe_to_mem_valid = 1'b1;
    step();
    step();
    checks++;
    if (mem_to_exe_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_full: ready=%b expected 0", mem_to_exe_ready);
    end
    rst = 1'b1;
    wb_to_mem_ready = 1'b1;
    step();
    rst = 1'b0;
    exe_to_mem_valid = 1'b0;
    checks++;
    if (mem_to_wb_valid !== 1'b0 || mem_to_exe_ready !== 1'b1 || mem_fwd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: valid=%b ready=%b fwd=%b expected 0 1 0",
               mem_to_wb_valid, mem_to_exe_ready, mem_fwd_valid);
    end
    $display("reset mid-op: valid=%b ready=%b", mem_to_wb_valid, mem_to_exe_ready);
    step();
  endtask

  task automatic test_lane_select();
    exe_to_mem_bus = mk_bus(1'b1, 5'd6, 32'h2, 3'd1, 32'h0080_0000);
    exe_to_mem_valid = 1'b1;
    step();
    exe_to_mem_valid = 1'b0;
`ifdef MEM_ALIGNED_LOAD_EN
    checks++;
    if (mem_fwd_data !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL lane_lb: data=%h expected ffffff80", mem_fwd_data);
    end
`else
    checks++;
    if (mem_fwd_data !== 32'h0) begin
      errors++;
      $display("FAIL lane_lb: data=%h expected 00000000", mem_fwd_data);
    end
`endif
    $display("lb at addr 2: wdata=%h", mem_fwd_data);
    step();
`ifdef MEM_ALIGNED_LOAD_EN
    exe_to_mem_bus = mk_bus(1'b1, 5'd7, 32'h1, 3'd3, 32'h1234_5678);
    exe_to_mem_valid = 1'b1;
    step();
    exe_to_mem_valid = 1'b0;
    checks++;
    if (mem_fwd_data !== 32'h0 || misalign_err !== 1'b1) begin
      errors++;
      $display("FAIL misalign_lw: data=%h err=%b expected 0 1", mem_fwd_data, misalign_err);
    end
    step();
    checks++;
    if (misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse: err=%b expected 0", misalign_err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_lb();
    test_load_ext();
    test_backpressure();
    test_back_to_back();
    test_x0_store();
    test_reset_mid();
    test_lane_select();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
